bus_req_arbiter: RTL and testbench
==================================

# bus_req_arbiter

Round-robin controller that shares the single `bus_module` write/read front end between `NUM_REQ` independent requesters. It sequences `bus_module`'s enable/valid protocol: one arm cycle, then a back-to-back valid stream, then a drop back to idle. It masks requests whose target switch FIFO is near full, and consumes requests with an out-of-range switch address so they never reach the bus.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `NUM_SW_INST`, 5, number of switch instances behind `bus_module`
- `W_WIDTH`, 8, write-data width
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in NUM_REQ: per-requester request
- `req_wr_rd` in NUM_REQ: per-requester write/read flag
- `req_op_id` in 8*NUM_REQ: op id, requester i in bits [8i+7:8i]
- `req_addr` in 8*NUM_REQ: address; [7:5] switch, [4:0] register
- `req_wr_data` in W_WIDTH*NUM_REQ: write data
- `sw_fifo_full` in NUM_SW_INST: almost-full per switch FIFO
- `req_ready` out NUM_REQ: one-hot, combinational, request accepted this cycle
- `req_err` out NUM_REQ: registered one-cycle pulse, request dropped (bad switch address)
- `bus_en` out 1: to `bus_module.en_in`, registered
- `bus_valid` out 1: to `bus_module.valid`, registered
- `bus_wr_rd_op`, `bus_op_id`[8], `bus_addr`[8], `bus_wr_data`[W_WIDTH] out: registered payload
- `bus_grant_id` out clog2(NUM_REQ): requester index of the current payload
- `busy` out 1: FSM not IDLE

## Operation
- Request i is **bad** when `req_addr[7:5] ≥ NUM_SW_INST`.
- Request i is **forwardable** when valid, not bad, and `sw_fifo_full[addr[7:5]]`=0.
- Requester rule: the payload is held stable while valid is high and ready is low. Valid must not drop before ready.
- Round-robin: the search starts at `last_ptr+1` mod NUM_REQ. `last_ptr` ← winner on every `req_ready`.
- FSM IDLE:
  - Candidates are all valid requests, bad or forwardable.
  - Bad winner: `req_ready` to it, `req_err` pulse next cycle, stay IDLE.
  - Forwardable winner: go to ARM with no ready. `bus_en`←1.
- FSM ARM:
  - `bus_en`=1 for this cycle only. Candidates are forwardable requests only.
  - On a winner: `req_ready` to it; payload and `bus_valid`←1, `bus_en`←0; go to XFER.
  - With none: `bus_en`←0, go to IDLE.
- FSM XFER:
  - `bus_valid`=1. Candidates are forwardable requests only.
  - On a winner: ready, load the new payload, stay XFER.
  - With none: `bus_valid`←0, payload←0, go to IDLE.
  - Bad requests wait for IDLE.
- Payload regs load only on a bus grant; otherwise they hold, and clear on the XFER→IDLE transition.
- Simultaneous events: at most one ready per cycle. A requester withdrawing in ARM is illegal (valid held), but a FIFO going full may empty the candidate set. That case is handled by the ARM→IDLE path.

## Timing
- Reset: all outputs 0, state IDLE, `last_ptr`=NUM_REQ-1, so requester 0 wins first.
- Reset mid-XFER clears immediately. `bus_module` must share the same reset source (inverted at top).
- Fresh request at cycle 0 (IDLE):
  - cycle 1: ARM, `bus_en`=1, `req_ready` pulse.
  - cycle 2: `bus_valid`=1 with payload.
  - cycle 3: `bus_module` `frame_out`/`fifo_wr_en` valid.
- Streaming throughput is 1 transaction/cycle.
- Re-arm after a gap costs 1 IDLE + 1 ARM cycle.
- On IDLE entry, `bus_module` drops to its idle state at the same edge the arbiter can set `bus_en`, so no cycle is lost.
- `sw_fifo_full` must assert with ≥2 free entries: the grant-to-FIFO-write latency is 2 cycles.

## Structure
- Package `bus_arb_pkg`:
  - state enum {IDLE, ARM, XFER}
  - `SW_ADDR_MSB`=7, `SW_ADDR_LSB`=5, `REG_ADDR_W`=5, `OP_ID_W`=8
- Sub-module `rr_picker`: combinational, (request mask, `last_ptr`) → one-hot grant plus index. It is instantiated once, with the candidate mask muxed by state.

## Test plan
- r0 `addr`=0x43, `data`=0xA5, `op_id`=0x11, `wr_rd`=1 at cycle 0 → `req_ready[0]` cycle 1, `bus_en`=1 cycle 1, `bus_valid` cycle 2 with that payload, `bus_module` `fifo_wr_en`=5'b00100 cycle 3.
- r0..r3 valid continuously, no full → single ARM, then grants 0,1,2,3,0 on consecutive cycles, `bus_valid` held high.
- `sw_fifo_full[2]`=1, r0 targets 0x40, r1 targets 0x05 → r1 served, r0 waits. Clear full → r0 served within 2 cycles (re-arm if the stream had ended).
- r2 `addr`=0xE0 in IDLE → `req_ready[2]` with no `bus_en`, then `req_err[2]` pulse next cycle. Same request during XFER waits until IDLE.
- Gap between two r1 requests → sequence XFER→IDLE→ARM→XFER, and both frames appear at `bus_module` output.
- `rst` pulse during XFER with r3 pending → outputs 0 asynchronously. After release r0 and r3 both pending → r0 granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and address-field constants for the bus request arbiter.
// The switch index sits in the top bits of each request address.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam int SW_ADDR_MSB = 7;
   localparam int SW_ADDR_LSB = 5;
   localparam int REG_ADDR_W  = 5;
   localparam int OP_ID_W     = 8;

endpackage

// File: rtl/bus_req_arbiter_rr_picker.sv
// Combinational round-robin picker: the search starts one past last_ptr
// and wraps, returning a one-hot grant plus the winner's index.
module rr_picker #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   int cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(last_ptr) + off) % NUM_REQ;
         if (!any && mask[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin front end sharing one bus_module between NUM_REQ requesters:
// one arm cycle, a back-to-back valid stream, then a drop back to idle.
module bus_req_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_SW_INST = 5,
   parameter int W_WIDTH     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_wr_rd,
   input  logic [8*NUM_REQ-1:0]         req_op_id,
   input  logic [8*NUM_REQ-1:0]         req_addr,
   input  logic [W_WIDTH*NUM_REQ-1:0]   req_wr_data,
   input  logic [NUM_SW_INST-1:0]       sw_fifo_full,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           req_err,
   output logic                         bus_en,
   output logic                         bus_valid,
   output logic                         bus_wr_rd_op,
   output logic [OP_ID_W-1:0]           bus_op_id,
   output logic [7:0]                   bus_addr,
   output logic [W_WIDTH-1:0]           bus_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]   bus_grant_id,
   output logic                         busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SW_W  = SW_ADDR_MSB - SW_ADDR_LSB + 1;

   state_t               state;
   logic [IDX_W-1:0]     last_ptr;
   logic [NUM_REQ-1:0]   bad;
   logic [NUM_REQ-1:0]   fwd;
   logic [NUM_REQ-1:0]   cand_mask;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_any;
   logic                 idle_bad_win;
   logic [SW_W-1:0]      sw;
   logic                 full_hit;
   logic                 sel_wr_rd;
   logic [OP_ID_W-1:0]   sel_op_id;
   logic [7:0]           sel_addr;
   logic [W_WIDTH-1:0]   sel_data;

   // A bad switch index is consumed with an error; a good one is held off while its FIFO is near full.
   always_comb begin
      bad      = '0;
      fwd      = '0;
      sw       = '0;
      full_hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sw       = req_addr[8*i+SW_ADDR_LSB +: SW_W];
         full_hit = 1'b0;
         for (int s = 0; s < NUM_SW_INST; s++) begin
            if (int'(sw) == s) full_hit = sw_fifo_full[s];
         end
         if (int'(sw) >= NUM_SW_INST) bad[i] = req_valid[i];
         else                         fwd[i] = req_valid[i] & ~full_hit;
      end
   end

   assign cand_mask = (state == IDLE) ? (bad | fwd) : fwd;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .mask      (cand_mask),
      .last_ptr  (last_ptr),
      .grant     (grant),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   assign idle_bad_win = (state == IDLE) && win_any && |(grant & bad);
   assign req_ready    = (idle_bad_win || (state != IDLE && win_any)) ? grant : '0;
   assign busy         = (state != IDLE);

   always_comb begin
      sel_wr_rd = 1'b0;
      sel_op_id = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_wr_rd = req_wr_rd[i];
            sel_op_id = req_op_id[OP_ID_W*i +: OP_ID_W];
            sel_addr  = req_addr[8*i +: 8];
            sel_data  = req_wr_data[W_WIDTH*i +: W_WIDTH];
         end
      end
   end

   // ARM holds bus_en for exactly one cycle; payload changes only on a bus grant or when a stream ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_ptr     <= IDX_W'(NUM_REQ - 1);
         req_err      <= '0;
         bus_en       <= 1'b0;
         bus_valid    <= 1'b0;
         bus_wr_rd_op <= 1'b0;
         bus_op_id    <= '0;
         bus_addr     <= '0;
         bus_wr_data  <= '0;
         bus_grant_id <= '0;
      end else begin
         req_err <= '0;
         if (|req_ready) last_ptr <= win_idx;
         case (state)
            IDLE: begin
               if (idle_bad_win) begin
                  req_err <= grant;
               end else if (win_any) begin
                  state  <= ARM;
                  bus_en <= 1'b1;
               end
            end
            ARM: begin
               bus_en <= 1'b0;
               if (win_any) begin
                  state        <= XFER;
                  bus_valid    <= 1'b1;
                  bus_wr_rd_op <= sel_wr_rd;
                  bus_op_id    <= sel_op_id;
                  bus_addr     <= sel_addr;
                  bus_wr_data  <= sel_data;
                  bus_grant_id <= win_idx;
               end else begin
                  state <= IDLE;
               end
            end
            XFER: begin
               if (win_any) begin
                  bus_wr_rd_op <= sel_wr_rd;
                  bus_op_id    <= sel_op_id;
                  bus_addr     <= sel_addr;
                  bus_wr_data  <= sel_data;
                  bus_grant_id <= win_idx;
               end else begin
                  state        <= IDLE;
                  bus_valid    <= 1'b0;
                  bus_wr_rd_op <= 1'b0;
                  bus_op_id    <= '0;
                  bus_addr     <= '0;
                  bus_wr_data  <= '0;
                  bus_grant_id <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Scoreboard bench for bus_req_arbiter: directed requests feed per-requester
// queues while a negedge monitor checks grants, bus payloads and error pulses.
module tb_bus_req_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int NUM_SW_INST = 5;
   localparam int W_WIDTH     = 8;

   typedef struct packed {
      logic       wr_rd;
      logic [7:0] op_id;
      logic [7:0] addr;
      logic [7:0] data;
   } req_t;

   logic                        clk          = 1'b0;
   logic                        rst          = 1'b1;
   logic [NUM_REQ-1:0]          req_valid    = '0;
   logic [NUM_REQ-1:0]          req_wr_rd    = '0;
   logic [8*NUM_REQ-1:0]        req_op_id    = '0;
   logic [8*NUM_REQ-1:0]        req_addr     = '0;
   logic [W_WIDTH*NUM_REQ-1:0]  req_wr_data  = '0;
   logic [NUM_SW_INST-1:0]      sw_fifo_full = '0;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ-1:0]          req_err;
   logic                        bus_en;
   logic                        bus_valid;
   logic                        bus_wr_rd_op;
   logic [7:0]                  bus_op_id;
   logic [7:0]                  bus_addr;
   logic [W_WIDTH-1:0]          bus_wr_data;
   logic [1:0]                  bus_grant_id;
   logic                        busy;

   req_t        pend [NUM_REQ][$];
   int          exp_ready[$];
   int          exp_err[$];
   logic [31:0] exp_bus[$];
   int          checks    = 0;
   int          errors    = 0;
   int          arm_count = 0;
   int          arm_base  = 0;
   logic [NUM_REQ-1:0] drv_acc;
   req_t        drv_r;
   int          mon_e;
   logic [31:0] mon_b;

   bus_req_arbiter #(
      .NUM_REQ(NUM_REQ), .NUM_SW_INST(NUM_SW_INST), .W_WIDTH(W_WIDTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_op_id(req_op_id),
      .req_addr(req_addr), .req_wr_data(req_wr_data), .sw_fifo_full(sw_fifo_full),
      .req_ready(req_ready), .req_err(req_err), .bus_en(bus_en), .bus_valid(bus_valid),
      .bus_wr_rd_op(bus_wr_rd_op), .bus_op_id(bus_op_id), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_grant_id(bus_grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_req(input int idx, input logic wr, input logic [7:0] id,
                           input logic [7:0] addr, input logic [7:0] data);
      pend[idx].push_back({wr, id, addr, data});
   endtask

   task automatic expect_grant(input int idx, input logic wr, input logic [7:0] id,
                               input logic [7:0] addr, input logic [7:0] data);
      exp_ready.push_back(idx);
      exp_bus.push_back(32'({2'(idx), wr, id, addr, data}));
   endtask

   task automatic expect_err(input int idx);
      exp_ready.push_back(idx);
      exp_err.push_back(idx);
   endtask

   function automatic bit pend_empty();
      for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (!busy && req_valid == '0 && req_err == '0 && pend_empty()) done = 1'b1;
      end
      check_output({name, "_idle"}, 32'(done), 32'd1);
      @(negedge clk);
      check_output({name, "_drained"}, 32'(exp_ready.size() + exp_bus.size() + exp_err.size()), 32'd0);
   endtask

   task automatic apply_stimulus_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Requester model: consume the head entry once ready was seen before the edge, then present the next one.
   always @(posedge clk) begin
      drv_acc = req_ready;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst) pend[i].delete();
         else if (drv_acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
         if (pend[i].size() > 0) begin
            drv_r                        = pend[i][0];
            req_valid[i]                 = 1'b1;
            req_wr_rd[i]                 = drv_r.wr_rd;
            req_op_id[8*i +: 8]          = drv_r.op_id;
            req_addr[8*i +: 8]           = drv_r.addr;
            req_wr_data[W_WIDTH*i +: 8]  = drv_r.data;
         end else begin
            req_valid[i]                 = 1'b0;
            req_wr_rd[i]                 = 1'b0;
            req_op_id[8*i +: 8]          = '0;
            req_addr[8*i +: 8]           = '0;
            req_wr_data[W_WIDTH*i +: 8]  = '0;
         end
      end
   end

   // Monitor: every ready, bus_valid cycle and error pulse must match the next expected entry.
   always @(negedge clk) begin
      if (rst) begin
         exp_ready.delete();
         exp_bus.delete();
         exp_err.delete();
      end else begin
         if (bus_en) arm_count++;
         if (req_ready != '0) begin
            if (exp_ready.size() == 0) check_output("ready_unexpected", 32'(req_ready), 32'd0);
            else begin
               mon_e = exp_ready.pop_front();
               check_output("ready_grant", 32'(req_ready), 32'd1 << mon_e);
            end
         end
         if (bus_valid) begin
            mon_b = 32'({bus_grant_id, bus_wr_rd_op, bus_op_id, bus_addr, bus_wr_data});
            if (exp_bus.size() == 0) check_output("bus_unexpected", mon_b, 32'hFFFF_FFFF);
            else check_output("bus_payload", mon_b, exp_bus.pop_front());
         end
         if (req_err != '0) begin
            if (exp_err.size() == 0) check_output("err_unexpected", 32'(req_err), 32'd0);
            else begin
               mon_e = exp_err.pop_front();
               check_output("err_pulse", 32'(req_err), 32'd1 << mon_e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit found;

      // Reset state
      repeat (2) @(negedge clk);
      check_output("reset_ctrl", 32'({bus_en, bus_valid, busy, req_err, req_ready}), 32'd0);
      check_output("reset_payload", 32'({bus_grant_id, bus_wr_rd_op, bus_op_id, bus_addr, bus_wr_data}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single fresh request: ARM with ready on cycle 1, payload on cycle 2
      $display("[TB] test: single request");
      arm_base = arm_count;
      push_req(0, 1'b1, 8'h11, 8'h43, 8'hA5);
      expect_grant(0, 1'b1, 8'h11, 8'h43, 8'hA5);
      @(posedge clk);
      @(negedge clk);
      check_output("c0_idle", 32'({bus_en, busy, req_ready}), 32'd0);
      @(negedge clk);
      check_output("c1_arm", 32'({bus_en, bus_valid, busy, req_ready}), 32'b1_0_1_0001);
      @(negedge clk);
      check_output("c2_valid", 32'({bus_en, bus_valid, bus_addr, bus_wr_data}), 32'({1'b0, 1'b1, 8'h43, 8'hA5}));
      wait_idle("single");
      check_output("single_arms", 32'(arm_count - arm_base), 32'd1);

      // All four streaming: one ARM, grants 0,1,2,3,0
      $display("[TB] test: streaming");
      apply_stimulus_reset();
      arm_base = arm_count;
      push_req(0, 1'b1, 8'h20, 8'h01, 8'h10);
      push_req(0, 1'b0, 8'h24, 8'h22, 8'h14);
      push_req(1, 1'b1, 8'h21, 8'h62, 8'h11);
      push_req(2, 1'b0, 8'h22, 8'h83, 8'h12);
      push_req(3, 1'b1, 8'h23, 8'h24, 8'h13);
      expect_grant(0, 1'b1, 8'h20, 8'h01, 8'h10);
      expect_grant(1, 1'b1, 8'h21, 8'h62, 8'h11);
      expect_grant(2, 1'b0, 8'h22, 8'h83, 8'h12);
      expect_grant(3, 1'b1, 8'h23, 8'h24, 8'h13);
      expect_grant(0, 1'b0, 8'h24, 8'h22, 8'h14);
      wait_idle("stream");
      check_output("stream_arms", 32'(arm_count - arm_base), 32'd1);

      // FIFO full masking: r1 served, r0 waits until full clears
      $display("[TB] test: fifo full");
      sw_fifo_full = 5'b00100;
      push_req(0, 1'b1, 8'h30, 8'h40, 8'h5A);
      push_req(1, 1'b0, 8'h31, 8'h05, 8'h6B);
      expect_grant(1, 1'b0, 8'h31, 8'h05, 8'h6B);
      expect_grant(0, 1'b1, 8'h30, 8'h40, 8'h5A);
      repeat (6) @(negedge clk);
      check_output("full_r0_waiting", 32'({req_valid[0], busy}), 32'b10);
      sw_fifo_full = '0;
      found = 1'b0;
      for (int n = 0; n < 2 && !found; n++) begin
         @(negedge clk);
         if (req_ready[0]) found = 1'b1;
      end
      check_output("full_r0_latency", 32'(found), 32'd1);
      wait_idle("full");

      // Bad address in IDLE: ready without bus_en, error pulse next cycle
      $display("[TB] test: bad address");
      arm_base = arm_count;
      push_req(2, 1'b1, 8'h40, 8'hE0, 8'h77);
      expect_err(2);
      @(posedge clk);
      @(negedge clk);
      check_output("bad_ready", 32'({bus_en, req_ready}), 32'b0_0100);
      @(negedge clk);
      check_output("bad_err", 32'({bus_en, req_err}), 32'b0_0100);
      wait_idle("bad_idle");
      check_output("bad_no_arm", 32'(arm_count - arm_base), 32'd0);

      // Bad request during a stream waits for IDLE
      push_req(0, 1'b1, 8'h50, 8'h21, 8'h01);
      push_req(0, 1'b0, 8'h51, 8'h42, 8'h02);
      push_req(0, 1'b1, 8'h52, 8'h63, 8'h03);
      push_req(2, 1'b0, 8'h53, 8'hE4, 8'h04);
      expect_grant(0, 1'b1, 8'h50, 8'h21, 8'h01);
      expect_grant(0, 1'b0, 8'h51, 8'h42, 8'h02);
      expect_grant(0, 1'b1, 8'h52, 8'h63, 8'h03);
      expect_err(2);
      wait_idle("bad_xfer");

      // Gap between two r1 requests needs a second ARM
      $display("[TB] test: re-arm after gap");
      arm_base = arm_count;
      push_req(1, 1'b1, 8'h60, 8'h81, 8'hC1);
      expect_grant(1, 1'b1, 8'h60, 8'h81, 8'hC1);
      wait_idle("gap_first");
      push_req(1, 1'b0, 8'h61, 8'h02, 8'hC2);
      expect_grant(1, 1'b0, 8'h61, 8'h02, 8'hC2);
      wait_idle("gap_second");
      check_output("gap_arms", 32'(arm_count - arm_base), 32'd2);

      // Asynchronous reset mid-stream, then pointer restarts at requester 0
      $display("[TB] test: reset during stream");
      sw_fifo_full = 5'b10000;
      push_req(0, 1'b1, 8'h70, 8'h01, 8'hD0);
      push_req(0, 1'b1, 8'h71, 8'h02, 8'hD1);
      push_req(0, 1'b1, 8'h72, 8'h03, 8'hD2);
      push_req(3, 1'b1, 8'h73, 8'h80, 8'hD3);
      expect_grant(0, 1'b1, 8'h70, 8'h01, 8'hD0);
      expect_grant(0, 1'b1, 8'h71, 8'h02, 8'hD1);
      expect_grant(0, 1'b1, 8'h72, 8'h03, 8'hD2);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (bus_valid) found = 1'b1;
      end
      check_output("rst_stream_seen", 32'(found), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_output("rst_async_ctrl", 32'({bus_en, bus_valid, busy, req_err}), 32'd0);
      check_output("rst_async_payload", 32'({bus_grant_id, bus_wr_rd_op, bus_op_id, bus_addr, bus_wr_data}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sw_fifo_full = '0;
      @(negedge clk);
      push_req(0, 1'b0, 8'h80, 8'h61, 8'hE0);
      push_req(3, 1'b1, 8'h83, 8'h82, 8'hE3);
      expect_grant(0, 1'b0, 8'h80, 8'h61, 8'hE0);
      expect_grant(3, 1'b1, 8'h83, 8'h82, 8'hE3);
      wait_idle("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
